// File: rtl/mem_arbiter_if.sv
// CPU, DMA and RAM-side signals of the two-requester RAM arbiter.
// The arbiter uses the slave modport; requesters and the RAM use the master modport.
interface mem_arbiter_if;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_wait;
  logic        cpu_rvalid;

  logic        dma_req;
  logic        dma_we;
  logic [7:0]  dma_addr;
  logic [15:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;

  logic [7:0]  ram_addr;
  logic        ram_write;
  logic [15:0] ram_din;

  modport slave (
    input  mem_cmd, mem_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata,
    output cpu_wait, cpu_rvalid, dma_gnt, dma_rvalid, ram_addr, ram_write, ram_din
  );

  modport master (
    output mem_cmd, mem_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata,
    input  cpu_wait, cpu_rvalid, dma_gnt, dma_rvalid, ram_addr, ram_write, ram_din
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single-port 256x16 RAM between the CPU and a DMA/debug requester.
// Define ARB_STARVE_GUARD_EN to force DMA through after MAX_CPU_RUN contended CPU grants.
module mem_arbiter #(
  parameter int unsigned MAX_CPU_RUN = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {OwnNone, OwnCpu, OwnDma} owner_e;

  owner_e rd_owner_q, rd_owner_d;
  logic   cpu_ram;
  logic   grant_cpu;
  logic   grant_dma;
  logic   starve;

  assign cpu_ram = ((bus.mem_cmd == 2'b01) || (bus.mem_cmd == 2'b10)) && !bus.mem_addr[8];

  // A zero limit leaves the run counter with no legal width.
  max_run_ok: assert property (@(posedge clk) MAX_CPU_RUN >= 1);

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned RunW = $clog2(MAX_CPU_RUN + 1);

  logic [RunW-1:0] run_cnt_q, run_cnt_d;

  assign starve = (run_cnt_q == RunW'(MAX_CPU_RUN));

  always_comb begin
    run_cnt_d = run_cnt_q;
    if (grant_dma || !bus.dma_req) begin
      run_cnt_d = '0;
    end else if (grant_cpu && !starve) begin
      run_cnt_d = run_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end
`else
  assign starve = 1'b0;
`endif

  // Grants are suppressed while reset is held so nothing reaches the RAM.
  always_comb begin
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    if (reset) begin
      if (cpu_ram && !(bus.dma_req && starve)) begin
        grant_cpu = 1'b1;
      end else if (bus.dma_req) begin
        grant_dma = 1'b1;
      end
    end
  end

  always_comb begin
    bus.ram_addr  = bus.mem_addr[7:0];
    bus.ram_din   = bus.cpu_wdata;
    bus.ram_write = 1'b0;
    bus.cpu_wait  = 1'b0;
    bus.dma_gnt   = 1'b0;
    rd_owner_d    = OwnNone;
    if (grant_cpu) begin
      bus.ram_write = (bus.mem_cmd == 2'b01);
      if (bus.mem_cmd == 2'b10) begin
        rd_owner_d = OwnCpu;
      end
    end else if (grant_dma) begin
      bus.ram_addr  = bus.dma_addr;
      bus.ram_din   = bus.dma_wdata;
      bus.ram_write = bus.dma_we;
      bus.dma_gnt   = 1'b1;
      bus.cpu_wait  = cpu_ram;
      if (!bus.dma_we) begin
        rd_owner_d = OwnDma;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_owner_q <= OwnNone;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  assign bus.cpu_rvalid = (rd_owner_q == OwnCpu);
  assign bus.dma_rvalid = (rd_owner_q == OwnDma);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner sequences, random vs. model.
module tb_mem_arbiter;
  localparam int MaxRun = 4;

  logic clk = 1'b0;
  logic reset;
  mem_arbiter_if bus ();

  logic [15:0] ram [256];
  logic [15:0] ram_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_CPU_RUN(MaxRun)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // RAM device with one-cycle read latency
  always @(posedge clk) begin
    if (bus.ram_write) ram[bus.ram_addr] <= bus.ram_din;
    ram_dout <= ram[bus.ram_addr];
  end

  typedef struct {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wd;
    logic        dreq;
    logic        dwe;
    logic [7:0]  daddr;
    logic [15:0] dwd;
    logic        wait_e;
    logic        gnt_e;
    logic        we_e;
    logic [7:0]  raddr_e;
    logic        crv_e;
    logic        drv_e;
    logic        chk_dout;
    logic [15:0] dout_e;
  } vec_t;

  vec_t vt [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd,
                       input logic dreq, input logic dwe, input logic [7:0] daddr,
                       input logic [15:0] dwd);
    bus.mem_cmd   = cmd;
    bus.mem_addr  = addr;
    bus.cpu_wdata = wd;
    bus.dma_req   = dreq;
    bus.dma_we    = dwe;
    bus.dma_addr  = daddr;
    bus.dma_wdata = dwd;
  endtask

  // Inputs change 1 after the edge; outputs are sampled 4 after the edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int          run;
  int          pend;
  logic [15:0] pend_data;
  logic [15:0] mdl [256];
  int          gnt_seen;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    reset = 1'b0;
    drive(2'b10, 9'h003, '0, '1, '0, 8'h10, '0);

    // Reset held with both requesting
    repeat (2) @(posedge clk);
    #4;
    check("rst_dma_gnt", 32'(bus.dma_gnt), 32'(0));
    check("rst_ram_write", 32'(bus.ram_write), 32'(0));
    check("rst_cpu_wait", 32'(bus.cpu_wait), 32'(0));
    check("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'(0));
    check("rst_dma_rvalid", 32'(bus.dma_rvalid), 32'(0));
    next_cycle();
    reset = 1'b1;
    #3;
    check("rel_cpu_first_gnt", 32'(bus.dma_gnt), 32'(0));
    check("rel_cpu_wait", 32'(bus.cpu_wait), 32'(0));
    check("rel_ram_addr", 32'(bus.ram_addr), 32'(8'h03));
    next_cycle();
    drive(2'b00, 9'h003, '0, '1, '0, 8'h10, '0);
    #3;
    check("rel_cpu_rvalid", 32'(bus.cpu_rvalid), 32'(1));
    check("rel_dma_gnt", 32'(bus.dma_gnt), 32'(1));
    next_cycle();
    drive('0, '0, '0, '0, '0, '0, '0);
    #3;
    check("rel_dma_rvalid", 32'(bus.dma_rvalid), 32'(1));

    // Vector table: each row sees the read-owner left by the row before
    vt[0]  = '{2'b01, 9'h005, 16'h1234, '0, '0, 8'h00, 16'h0000, '0, '0, '1, 8'h05, '0, '0, '0, 16'h0000};
    vt[1]  = '{2'b10, 9'h005, 16'h0000, '0, '0, 8'h00, 16'h0000, '0, '0, '0, 8'h05, '0, '0, '0, 16'h0000};
    vt[2]  = '{2'b00, 9'h033, 16'h0000, '0, '0, 8'h00, 16'h0000, '0, '0, '0, 8'h33, '1, '0, '1, 16'h1234};
    vt[3]  = '{2'b01, 9'h100, 16'hffff, '1, '1, 8'h20, 16'hbeef, '0, '1, '1, 8'h20, '0, '0, '0, 16'h0000};
    vt[4]  = '{2'b10, 9'h007, 16'h0000, '1, '0, 8'h20, 16'h0000, '0, '0, '0, 8'h07, '0, '0, '0, 16'h0000};
    vt[5]  = '{2'b11, 9'h0aa, 16'h0000, '1, '0, 8'h20, 16'h0000, '0, '1, '0, 8'h20, '1, '0, '1, 16'h0000};
    vt[6]  = '{2'b00, 9'h012, 16'h0000, '0, '0, 8'h00, 16'h0000, '0, '0, '0, 8'h12, '0, '1, '1, 16'hbeef};
    vt[7]  = '{2'b01, 9'h040, 16'h5555, '1, '1, 8'h41, 16'h6666, '0, '0, '1, 8'h40, '0, '0, '0, 16'h0000};
    vt[8]  = '{2'b10, 9'h040, 16'h0000, '1, '1, 8'h41, 16'h6666, '0, '0, '0, 8'h40, '0, '0, '0, 16'h0000};
    vt[9]  = '{2'b00, 9'h040, 16'h0000, '1, '1, 8'h41, 16'h6666, '0, '1, '1, 8'h41, '1, '0, '1, 16'h5555};
    vt[10] = '{2'b00, 9'h000, 16'h0000, '0, '0, 8'h00, 16'h0000, '0, '0, '0, 8'h00, '0, '0, '0, 16'h0000};
    for (int i = 0; i < 11; i++) begin
      next_cycle();
      drive(vt[i].cmd, vt[i].addr, vt[i].wd, vt[i].dreq, vt[i].dwe, vt[i].daddr, vt[i].dwd);
      #3;
      check($sformatf("v%0d_cpu_wait", i), 32'(bus.cpu_wait), 32'(vt[i].wait_e));
      check($sformatf("v%0d_dma_gnt", i), 32'(bus.dma_gnt), 32'(vt[i].gnt_e));
      check($sformatf("v%0d_ram_write", i), 32'(bus.ram_write), 32'(vt[i].we_e));
      check($sformatf("v%0d_ram_addr", i), 32'(bus.ram_addr), 32'(vt[i].raddr_e));
      check($sformatf("v%0d_cpu_rvalid", i), 32'(bus.cpu_rvalid), 32'(vt[i].crv_e));
      check($sformatf("v%0d_dma_rvalid", i), 32'(bus.dma_rvalid), 32'(vt[i].drv_e));
      if (vt[i].chk_dout) check($sformatf("v%0d_ram_dout", i), 32'(ram_dout), 32'(vt[i].dout_e));
    end

    // Continuous CPU reads with a DMA read of 0x10 pending
`ifdef ARB_STARVE_GUARD_EN
    for (int i = 1; i <= MaxRun + 1; i++) begin
      next_cycle();
      drive(2'b10, 9'h060, '0, '1, '0, 8'h10, '0);
      #3;
      if (i <= MaxRun) begin
        check($sformatf("guard_gnt_c%0d", i), 32'(bus.dma_gnt), 32'(0));
      end else begin
        check("guard_gnt_forced", 32'(bus.dma_gnt), 32'(1));
        check("guard_cpu_wait", 32'(bus.cpu_wait), 32'(1));
      end
    end
    next_cycle();
    drive(2'b10, 9'h060, '0, '0, '0, 8'h10, '0);
    #3;
    check("guard_dma_rvalid", 32'(bus.dma_rvalid), 32'(1));
    check("guard_cpu_rvalid_stalled", 32'(bus.cpu_rvalid), 32'(0));
    check("guard_dma_dout", 32'(ram_dout), 32'(0));
    next_cycle();
    drive('0, '0, '0, '0, '0, '0, '0);
    #3;
    check("guard_cpu_rvalid_after", 32'(bus.cpu_rvalid), 32'(1));
`else
    gnt_seen = 0;
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      drive(2'b10, 9'h060, '0, '1, '0, 8'h10, '0);
      #3;
      if (bus.dma_gnt) gnt_seen++;
    end
    check("strict_no_dma_gnt_20", 32'(gnt_seen), 32'(0));
    next_cycle();
    drive(2'b00, 9'h060, '0, '1, '0, 8'h10, '0);
    #3;
    check("strict_gnt_on_idle", 32'(bus.dma_gnt), 32'(1));
    check("strict_cpu_rvalid", 32'(bus.cpu_rvalid), 32'(1));
    next_cycle();
    drive('0, '0, '0, '0, '0, '0, '0);
    #3;
    check("strict_dma_rvalid", 32'(bus.dma_rvalid), 32'(1));
`endif

    // DMA read granted, reset asserted before the edge that would load its owner
    next_cycle();
    drive(2'b00, 9'h000, '0, '1, '0, 8'h41, '0);
    #3;
    check("rmid_gnt", 32'(bus.dma_gnt), 32'(1));
    #4;
    reset = 1'b0;
    next_cycle();
    drive('0, '0, '0, '0, '0, '0, '0);
    #3;
    check("rmid_dma_rvalid_in_reset", 32'(bus.dma_rvalid), 32'(0));
    next_cycle();
    reset = 1'b1;
    #3;
    check("rmid_dma_rvalid_release", 32'(bus.dma_rvalid), 32'(0));
    next_cycle();
    #3;
    check("rmid_dma_rvalid_after", 32'(bus.dma_rvalid), 32'(0));

    // Random traffic against a cycle-level model of the arbitration rules
    begin
      logic [1:0]  cmd;
      logic [8:0]  addr;
      logic [15:0] wd;
      logic        dreq, dwe;
      logic [7:0]  daddr;
      logic [15:0] dwd;
      logic        cpu_hold, dma_hold;
      logic        cpu_ram, cpu_win, dma_win, guard;
      logic [7:0]  e_addr;
      logic [15:0] e_din;
      logic        e_we;
      for (int i = 0; i < 256; i++) mdl[i] = ram[i];
      run = 0;
      pend = 0;
      pend_data = '0;
      cpu_hold = 1'b0;
      dma_hold = 1'b0;
      cmd = '0; addr = '0; wd = '0; dreq = '0; dwe = '0; daddr = '0; dwd = '0;
      for (int c = 0; c < 400; c++) begin
        next_cycle();
        if (!cpu_hold) begin
          cmd  = 2'($urandom_range(0, 3));
          addr = {1'($urandom_range(0, 7) == 0), 8'($urandom)};
          wd   = 16'($urandom);
        end
        if (!dma_hold) begin
          dreq  = 1'($urandom_range(0, 1));
          dwe   = 1'($urandom_range(0, 1));
          daddr = 8'($urandom);
          dwd   = 16'($urandom);
        end
        drive(cmd, addr, wd, dreq, dwe, daddr, dwd);
        #3;
        cpu_ram = ((cmd == 2'd1) || (cmd == 2'd2)) && !addr[8];
`ifdef ARB_STARVE_GUARD_EN
        guard = (run == MaxRun);
`else
        guard = 1'b0;
`endif
        cpu_win = cpu_ram && !(dreq && guard);
        dma_win = dreq && !cpu_win;
        e_addr = dma_win ? daddr : addr[7:0];
        e_din  = dma_win ? dwd : wd;
        e_we   = (cpu_win && cmd == 2'd1) || (dma_win && dwe);
        check("rnd_dma_gnt", 32'(bus.dma_gnt), 32'(dma_win));
        check("rnd_cpu_wait", 32'(bus.cpu_wait), 32'(dma_win && cpu_ram));
        check("rnd_ram_write", 32'(bus.ram_write), 32'(e_we));
        check("rnd_ram_addr", 32'(bus.ram_addr), 32'(e_addr));
        check("rnd_ram_din", 32'(bus.ram_din), 32'(e_din));
        check("rnd_cpu_rvalid", 32'(bus.cpu_rvalid), 32'(pend == 1));
        check("rnd_dma_rvalid", 32'(bus.dma_rvalid), 32'(pend == 2));
        if (pend != 0) check("rnd_ram_dout", 32'(ram_dout), 32'(pend_data));
        pend = 0;
        if (cpu_win && cmd == 2'd2) begin
          pend = 1;
          pend_data = mdl[addr[7:0]];
        end else if (dma_win && !dwe) begin
          pend = 2;
          pend_data = mdl[daddr];
        end
        if (e_we) mdl[e_addr] = e_din;
        if (cpu_win && dreq) run = (run < MaxRun) ? run + 1 : run;
        else run = 0;
        cpu_hold = dma_win && cpu_ram;
        dma_hold = dreq && !dma_win;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
